// File: rtl/class_fifo.sv
// -----------------------------------------------------------------------------
// class_fifo
// Per-class buffer placed behind one output of the 1:2 class demultiplexer.
// Words are captured on push, kept in arrival order, and returned on pop to the
// downstream arbiter/mux stage. Occupancy is reported as full/empty and as
// almost-full/almost-empty against live thresholds. Dropped pushes and ignored
// pops raise one-cycle error pulses.
//
// Ports
//   clk               rising-edge clock
//   reset             synchronous active-high reset, overrides everything
//   push, data_in     write request and write data
//   pop               read request
//   almost_full_thr   almost-full level (1..DEPTH)
//   almost_empty_thr  almost-empty level (0..DEPTH-1)
//   data_out          registered read data, holds between pops
//   valid_out         one-cycle strobe marking a freshly popped word
//   full, empty, almost_full, almost_empty   occupancy flags from count
//   overflow_err      pulse: push dropped because the FIFO was full
//   underflow_err     pulse: pop ignored because the FIFO was empty
//   count             number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module class_fifo #(
    parameter int DATA_WIDTH = 10,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    input  logic [ADDR_WIDTH:0]   almost_full_thr,
    input  logic [ADDR_WIDTH:0]   almost_empty_thr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow_err,
    output logic                  underflow_err,
    output logic [ADDR_WIDTH:0]   count
);

    localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;

    logic full_s, empty_s;
    logic push_ok_s, pop_ok_s;

    assign full_s  = (count_q == FULL_CNT);
    assign empty_s = (count_q == {(ADDR_WIDTH + 1){1'b0}});

    // A push is still accepted while full if a pop frees a slot in the same
    // cycle; a pop on an empty FIFO never sees the word being pushed.
    assign push_ok_s = push & (~full_s | pop);
    assign pop_ok_s  = pop & ~empty_s;

    // Next-state for storage: write the accepted word at the write pointer.
    always_comb begin
        mem_d = mem_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = data_in;
        end else begin
            mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
        end
    end

    // Next-state for pointers, count, read data and error pulses.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        ovf_d      = push & full_s & ~pop;
        udf_d      = pop & empty_s;

        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_ok_s) begin
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            data_out_d = mem_q[rd_ptr_q];
            valid_d    = 1'b1;
        end else begin
            rd_ptr_d   = rd_ptr_q;
            data_out_d = data_out_q;
            valid_d    = 1'b0;
        end

        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Storage array; contents are left as-is on reset and the write is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= mem_q;
        end else begin
            mem_q <= mem_d;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= {ADDR_WIDTH{1'b0}};
            rd_ptr_q   <= {ADDR_WIDTH{1'b0}};
            count_q    <= {(ADDR_WIDTH + 1){1'b0}};
            data_out_q <= {DATA_WIDTH{1'b0}};
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    // Thresholds are live inputs, so the almost flags follow them without delay.
    assign full          = full_s;
    assign empty         = empty_s;
    assign almost_full   = (count_q >= almost_full_thr);
    assign almost_empty  = (count_q <= almost_empty_thr);
    assign data_out      = data_out_q;
    assign valid_out     = valid_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = udf_q;
    assign count         = count_q;

endmodule

// File: tb/tb_class_fifo.sv
module tb_class_fifo;

    logic       clk;
    logic       reset;
    logic       push;
    logic [9:0] data_in;
    logic       pop;
    logic [3:0] almost_full_thr;
    logic [3:0] almost_empty_thr;
    logic [9:0] data_out;
    logic       valid_out;
    logic       full, empty, almost_full, almost_empty;
    logic       overflow_err, underflow_err;
    logic [3:0] count;

    int checks = 0;
    int errors = 0;

    class_fifo #(.DATA_WIDTH(10), .DEPTH(8), .ADDR_WIDTH(3)) dut (
        .clk              (clk),
        .reset            (reset),
        .push             (push),
        .data_in          (data_in),
        .pop              (pop),
        .almost_full_thr  (almost_full_thr),
        .almost_empty_thr (almost_empty_thr),
        .data_out         (data_out),
        .valid_out        (valid_out),
        .full             (full),
        .empty            (empty),
        .almost_full      (almost_full),
        .almost_empty     (almost_empty),
        .overflow_err     (overflow_err),
        .underflow_err    (underflow_err),
        .count            (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       push;
        logic [9:0] din;
        logic       pop;
        logic [3:0] aft;
        logic [3:0] aet;
        logic [9:0] dout;
        logic       vld;
        logic [3:0] cnt;
        logic       ovf;
        logic       udf;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic psh, input logic [9:0] din,
                                input logic pp, input logic [3:0] aft, input logic [3:0] aet,
                                input logic [9:0] dout, input logic vld, input logic [3:0] cnt,
                                input logic ovf, input logic udf);
        vec_t v;
        v.rst = rst; v.push = psh; v.din = din; v.pop = pp;
        v.aft = aft; v.aet = aet; v.dout = dout; v.vld = vld;
        v.cnt = cnt; v.ovf = ovf; v.udf = udf;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at step %0d: got 0x%0h expected 0x%0h", name, idx, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; push = 1'b0; data_in = 10'h000; pop = 1'b0;
        almost_full_thr = 4'd6; almost_empty_thr = 4'd2;

        // rst push din pop aft aet | dout vld cnt ovf udf
        add(1'b1, 1'b1, 10'h3FF, 1'b1, 4'd6, 4'd2, 10'h000, 1'b0, 4'd0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 10'h000, 1'b0, 4'd6, 4'd2, 10'h000, 1'b0, 4'd0, 1'b0, 1'b0);
        // Fill with 0x001..0x006, then raise almost_full_thr to 7 for one step.
        for (int i = 0; i < 6; i++)
            add(1'b0, 1'b1, 10'h001 + 10'(i), 1'b0, 4'd6, 4'd2, 10'h000, 1'b0, 4'(i + 1), 1'b0, 1'b0);
        add(1'b0, 1'b0, 10'h000, 1'b0, 4'd7, 4'd2, 10'h000, 1'b0, 4'd6, 1'b0, 1'b0);
        add(1'b0, 1'b1, 10'h007, 1'b0, 4'd6, 4'd2, 10'h000, 1'b0, 4'd7, 1'b0, 1'b0);
        add(1'b0, 1'b1, 10'h008, 1'b0, 4'd6, 4'd2, 10'h000, 1'b0, 4'd8, 1'b0, 1'b0);
        // Two dropped pushes back to back, then the pulse clears.
        add(1'b0, 1'b1, 10'h3FF, 1'b0, 4'd6, 4'd2, 10'h000, 1'b0, 4'd8, 1'b1, 1'b0);
        add(1'b0, 1'b1, 10'h3FF, 1'b0, 4'd6, 4'd2, 10'h000, 1'b0, 4'd8, 1'b1, 1'b0);
        add(1'b0, 1'b0, 10'h000, 1'b0, 4'd6, 4'd2, 10'h000, 1'b0, 4'd8, 1'b0, 1'b0);
        // Drain in order, then one ignored pop.
        for (int i = 0; i < 8; i++)
            add(1'b0, 1'b0, 10'h000, 1'b1, 4'd6, 4'd2, 10'h001 + 10'(i), 1'b1, 4'(7 - i), 1'b0, 1'b0);
        add(1'b0, 1'b0, 10'h000, 1'b1, 4'd6, 4'd2, 10'h008, 1'b0, 4'd0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 10'h000, 1'b0, 4'd6, 4'd2, 10'h008, 1'b0, 4'd0, 1'b0, 1'b0);
        // Refill, then push+pop while full: 0x155 is appended behind 0x012..0x018.
        for (int i = 0; i < 8; i++)
            add(1'b0, 1'b1, 10'h011 + 10'(i), 1'b0, 4'd6, 4'd2, 10'h008, 1'b0, 4'(i + 1), 1'b0, 1'b0);
        add(1'b0, 1'b1, 10'h155, 1'b1, 4'd6, 4'd2, 10'h011, 1'b1, 4'd8, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++)
            add(1'b0, 1'b0, 10'h000, 1'b1, 4'd6, 4'd2, 10'h012 + 10'(i), 1'b1, 4'(7 - i), 1'b0, 1'b0);
        add(1'b0, 1'b0, 10'h000, 1'b1, 4'd6, 4'd2, 10'h155, 1'b1, 4'd0, 1'b0, 1'b0);
        // Push+pop while empty: pop ignored, word stored.
        add(1'b0, 1'b1, 10'h2AA, 1'b1, 4'd6, 4'd2, 10'h155, 1'b0, 4'd1, 1'b0, 1'b1);
        add(1'b0, 1'b0, 10'h000, 1'b1, 4'd6, 4'd2, 10'h2AA, 1'b1, 4'd0, 1'b0, 1'b0);
        // Five pushes, then reset mid-burst together with a push.
        for (int i = 0; i < 5; i++)
            add(1'b0, 1'b1, 10'h021 + 10'(i), 1'b0, 4'd6, 4'd2, 10'h2AA, 1'b0, 4'(i + 1), 1'b0, 1'b0);
        add(1'b1, 1'b1, 10'h3FF, 1'b0, 4'd6, 4'd2, 10'h000, 1'b0, 4'd0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 10'h000, 1'b0, 4'd6, 4'd2, 10'h000, 1'b0, 4'd0, 1'b0, 1'b0);
        // Streaming push+pop across the 7 -> 0 pointer wrap.
        add(1'b0, 1'b1, 10'h030, 1'b0, 4'd6, 4'd2, 10'h000, 1'b0, 4'd1, 1'b0, 1'b0);
        for (int k = 1; k < 12; k++)
            add(1'b0, 1'b1, 10'h030 + 10'(k), 1'b1, 4'd6, 4'd2, 10'h030 + 10'(k - 1), 1'b1, 4'd1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 10'h000, 1'b1, 4'd6, 4'd2, 10'h03B, 1'b1, 4'd0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset            = vecs[i].rst;
            push             = vecs[i].push;
            data_in          = vecs[i].din;
            pop              = vecs[i].pop;
            almost_full_thr  = vecs[i].aft;
            almost_empty_thr = vecs[i].aet;
            @(posedge clk);
            #1;
            chk("count",         i, 32'(count),         32'(vecs[i].cnt));
            chk("data_out",      i, 32'(data_out),      32'(vecs[i].dout));
            chk("valid_out",     i, 32'(valid_out),     32'(vecs[i].vld));
            chk("overflow_err",  i, 32'(overflow_err),  32'(vecs[i].ovf));
            chk("underflow_err", i, 32'(underflow_err), 32'(vecs[i].udf));
            chk("full",          i, 32'(full),          32'(vecs[i].cnt == 4'd8));
            chk("empty",         i, 32'(empty),         32'(vecs[i].cnt == 4'd0));
            chk("almost_full",   i, 32'(almost_full),   32'(vecs[i].cnt >= vecs[i].aft));
            chk("almost_empty",  i, 32'(almost_empty),  32'(vecs[i].cnt <= vecs[i].aet));
        end

        // Threshold changes must show on the flags without a clock edge.
        reset = 1'b0; push = 1'b0; pop = 1'b0;
        almost_full_thr = 4'd1; almost_empty_thr = 4'd0;
        #1;
        chk("live_af_empty", 1000, 32'(almost_full),  32'(1'b0));
        chk("live_ae_empty", 1000, 32'(almost_empty), 32'(1'b1));
        @(negedge clk);
        push = 1'b1; data_in = 10'h0F0;
        @(posedge clk);
        #1;
        push = 1'b0;
        chk("live_count", 1001, 32'(count),        32'd1);
        chk("live_af_one", 1001, 32'(almost_full),  32'(1'b1));
        chk("live_ae_one", 1001, 32'(almost_empty), 32'(1'b0));
        almost_full_thr = 4'd2; almost_empty_thr = 4'd1;
        #1;
        chk("live_af_raise", 1002, 32'(almost_full),  32'(1'b0));
        chk("live_ae_raise", 1002, 32'(almost_empty), 32'(1'b1));
        @(negedge clk);
        pop = 1'b1;
        @(posedge clk);
        #1;
        pop = 1'b0;
        chk("live_pop_data", 1003, 32'(data_out), 32'(10'h0F0));
        chk("live_pop_empty", 1003, 32'(empty),   32'(1'b1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
